mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Memory-stage load/store sequencer between pipeline MEM stage and the data bus (dbus).
//  Accepts one access at a time, checks alignment, drives the dbus req/resp handshake,
//  builds store strobes/lane data, and aligns/sign-extends load data.
//  Stalls the pipeline via mreq_ready while an access is in flight.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles in ADDR+DATA before bus-error abort (only with MEM_CTRL_TIMEOUT_EN)
// PORTS
//  clk            in   1   clock, all state on posedge
//  reset          in   1   synchronous, active-high
//  mreq_valid     in   1   MEM stage has an access
//  mreq_ready     out  1   controller idle, access accepted this cycle if mreq_valid
//  mreq_write     in   1   1=store 0=load
//  mreq_addr      in   64  byte address
//  mreq_size      in   2   msize_t: MSIZE1/2/4/8
//  mreq_unsigned  in   1   load zero-extends (else sign-extends)
//  mreq_wdata     in   64  store data, right-justified
//  flush          in   1   squash in-flight access (exception/redirect)
//  mresp_valid    out  1   one-cycle completion pulse
//  mresp_rdata    out  64  aligned, extended load data (0 for stores)
//  mresp_addr_exc out  1   misaligned access, no bus traffic issued
//  mresp_bus_err  out  1   timeout abort (0 when macro off)
//  dreq_valid     out  1   dbus request valid
//  dreq_addr      out  64  = latched mreq_addr
//  dreq_size      out  2   = latched mreq_size
//  dreq_strobe    out  8   byte-lane write enables, 0 for loads
//  dreq_data      out  64  store data shifted to lane addr[2:0]*8
//  dresp_addr_ok  in   1   address accepted by bus
//  dresp_data_ok  in   1   data phase complete
//  dresp_data     in   64  raw 64-bit aligned load word
// BEHAVIOUR
//  - Reset: state=IDLE; mreq_ready=1; mresp_*=0; dreq_valid=0, dreq_strobe=0.
//  - States IDLE, ADDR, DATA, DONE, DRAIN. mreq_ready = (state==IDLE) & ~flush.
//  - IDLE: on mreq_valid&mreq_ready latch all mreq_* fields. Misaligned (size2: a[0];
//    size4: a[1:0]!=0; size8: a[2:0]!=0) -> DONE with addr_exc=1; else -> ADDR.
//  - ADDR: dreq_valid=1, dreq_* stable from latch. addr_ok&data_ok -> DONE;
//    addr_ok only -> DATA; else stay.
//  - DATA: dreq_valid=0; data_ok -> DONE (capture dresp_data); else stay.
//  - DONE: mresp_valid=1 for exactly one cycle, -> IDLE. Min latency accept->mresp_valid:
//    2 cycles (addr_ok&data_ok in first ADDR cycle); misaligned: 1 cycle.
//  - Strobe: MSIZE1 8'h01, MSIZE2 8'h03, MSIZE4 8'h0F, MSIZE8 8'hFF, shifted left by a[2:0].
//  - Load: field = dresp_data >> (a[2:0]*8), width by size; upper bits = field MSB unless
//    unsigned or MSIZE8; stores return rdata=0.
//  - flush in IDLE/DONE: no response issued (DONE pulse suppressed) -> IDLE.
//    flush in ADDR before addr_ok: drop dreq_valid next cycle -> IDLE.
//    flush in ADDR with addr_ok, or in DATA: -> DRAIN; wait data_ok, discard, -> IDLE, no mresp.
//  - DRAIN: mreq_ready=0, dreq_valid=0. flush repeated in DRAIN has no extra effect.
//  - reset mid-access: IDLE next cycle regardless of bus; dreq_valid low that cycle.
// CONFIGURATION
//  MEM_CTRL_TIMEOUT_EN defined: counter clears on ADDR entry, increments each ADDR/DATA/DRAIN
//   cycle; reaching TIMEOUT_CYCLES-1 without data_ok -> DONE with bus_err=1, rdata=0
//   (from DRAIN -> IDLE, no response). Later stray data_ok in IDLE is ignored.
//  Undefined: no counter, mresp_bus_err tied 0, controller waits indefinitely.
// TESTING
//  - LB a=..3, dresp_data=64'h0000_0000_8000_0000 unsigned=0, addr_ok&data_ok same cycle
//    -> mresp_valid 2 cycles after accept, rdata=64'hFFFF_FFFF_FFFF_FF80.
//  - LWU a=..4, data=64'h89AB_CDEF_0000_0000, data_ok 3 cycles after addr_ok -> rdata=64'h89AB_CDEF.
//  - SH a=..6 wdata=16'hBEEF -> dreq_strobe=8'hC0, dreq_data[63:48]=16'hBEEF, rdata=0.
//  - LD a=..4 -> no dreq_valid, mresp_valid 1 cycle after accept with addr_exc=1.
//  - Load, flush in cycle after addr_ok -> DRAIN, no mresp_valid; mreq_ready=1 only after data_ok.
//  - MEM_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=8, addr_ok never -> mresp_valid & bus_err after 8 cycles.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// MEM-stage request/response and dbus handshake bundle for mem_access_ctrl.
// slave = the controller, master = pipeline plus data bus on the other side.
interface mem_access_ctrl_if;
    logic        mreq_valid;
    logic        mreq_ready;
    logic        mreq_write;
    logic [63:0] mreq_addr;
    logic [1:0]  mreq_size;
    logic        mreq_unsigned;
    logic [63:0] mreq_wdata;
    logic        flush;
    logic        mresp_valid;
    logic [63:0] mresp_rdata;
    logic        mresp_addr_exc;
    logic        mresp_bus_err;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;

    modport slave (
        input  mreq_valid, mreq_write, mreq_addr, mreq_size, mreq_unsigned, mreq_wdata, flush,
               dresp_addr_ok, dresp_data_ok, dresp_data,
        output mreq_ready, mresp_valid, mresp_rdata, mresp_addr_exc, mresp_bus_err,
               dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
    );

    modport master (
        output mreq_valid, mreq_write, mreq_addr, mreq_size, mreq_unsigned, mreq_wdata, flush,
               dresp_addr_ok, dresp_data_ok, dresp_data,
        input  mreq_ready, mresp_valid, mresp_rdata, mresp_addr_exc, mresp_bus_err,
               dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM stage and the data bus, one access in flight.
// Optional bus timeout abort enabled by defining MEM_CTRL_TIMEOUT_EN.
module mem_access_ctrl
`ifdef MEM_CTRL_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 256
)
`endif
(
    input  logic             i_clk,
    input  logic             i_reset,
    mem_access_ctrl_if.slave io_bus
);
    localparam logic [1:0] MSIZE1 = 2'd0;
    localparam logic [1:0] MSIZE2 = 2'd1;
    localparam logic [1:0] MSIZE4 = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DONE, S_DRAIN} state_t;

    state_t      r_state, w_next;
    logic        r_write, r_unsigned, r_addr_exc, r_bus_err;
    logic [63:0] r_addr, r_wdata, r_rdata;
    logic [1:0]  r_size;
    logic        w_misaligned, w_accept, w_capture, w_abort, w_timeout, w_resp;
    logic [7:0]  w_strobe_base;

    function automatic logic [63:0] f_load_ext(input logic [63:0] raw, input logic [2:0] lane,
                                               input logic [1:0] size, input logic uns);
        logic [63:0] s;
        logic [63:0] r;
        s = raw >> {lane, 3'b000};
        case (size)
            MSIZE1:  r = uns ? {56'd0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
            MSIZE2:  r = uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            MSIZE4:  r = uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    always_comb begin
        case (io_bus.mreq_size)
            MSIZE1:  w_misaligned = 1'b0;
            MSIZE2:  w_misaligned = io_bus.mreq_addr[0];
            MSIZE4:  w_misaligned = |io_bus.mreq_addr[1:0];
            default: w_misaligned = |io_bus.mreq_addr[2:0];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Flush wins over completion and timeout; a flushed beat that already finished is just dropped.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.mreq_valid && !io_bus.flush) begin
                    w_accept = 1'b1;
                    w_next   = w_misaligned ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                if (io_bus.flush) begin
                    w_next = (io_bus.dresp_addr_ok && !io_bus.dresp_data_ok) ? S_DRAIN : S_IDLE;
                end else if (io_bus.dresp_addr_ok && io_bus.dresp_data_ok) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = S_DONE;
                end else if (io_bus.dresp_addr_ok) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (io_bus.dresp_data_ok) begin
                    w_capture = !io_bus.flush;
                    w_next    = io_bus.flush ? S_IDLE : S_DONE;
                end else if (io_bus.flush) begin
                    w_next = S_DRAIN;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_DRAIN: if (io_bus.dresp_data_ok || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_addr     <= 64'd0;
            r_size     <= 2'd0;
            r_wdata    <= 64'd0;
            r_rdata    <= 64'd0;
            r_addr_exc <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write    <= io_bus.mreq_write;
                r_unsigned <= io_bus.mreq_unsigned;
                r_addr     <= io_bus.mreq_addr;
                r_size     <= io_bus.mreq_size;
                r_wdata    <= io_bus.mreq_wdata;
                r_rdata    <= 64'd0;
                r_addr_exc <= w_misaligned;
                r_bus_err  <= 1'b0;
            end
            if (w_capture) begin
                r_rdata <= r_write ? 64'd0 : f_load_ext(io_bus.dresp_data, r_addr[2:0], r_size, r_unsigned);
            end
            if (w_abort) begin
                r_rdata   <= 64'd0;
                r_bus_err <= 1'b1;
            end
        end
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] r_tmo_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || w_accept) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_ADDR || r_state == S_DATA || r_state == S_DRAIN) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        case (r_size)
            MSIZE1:  w_strobe_base = 8'h01;
            MSIZE2:  w_strobe_base = 8'h03;
            MSIZE4:  w_strobe_base = 8'h0F;
            default: w_strobe_base = 8'hFF;
        endcase
    end

    assign w_resp                = (r_state == S_DONE) && !io_bus.flush && !i_reset;
    assign io_bus.mreq_ready     = (r_state == S_IDLE) && !io_bus.flush;
    assign io_bus.mresp_valid    = w_resp;
    assign io_bus.mresp_rdata    = w_resp ? r_rdata : 64'd0;
    assign io_bus.mresp_addr_exc = w_resp && r_addr_exc;
    assign io_bus.mresp_bus_err  = w_resp && r_bus_err;
    assign io_bus.dreq_valid     = (r_state == S_ADDR) && !i_reset;
    assign io_bus.dreq_addr      = r_addr;
    assign io_bus.dreq_size      = r_size;
    assign io_bus.dreq_strobe    = r_write ? (w_strobe_base << r_addr[2:0]) : 8'h00;
    assign io_bus.dreq_data      = r_wdata << {r_addr[2:0], 3'b000};
endmodule
